// File: rtl/pong_screen_pkg.sv
// Shared definitions for the PONG screen path: state codes, menu hit boxes
// and pixel width, used by both the sequencer and the menu renderer.
package pong_screen_pkg;

    localparam int unsigned RGB_W = 12;

    localparam logic [1:0] ST_MENU    = 2'd0;
    localparam logic [1:0] ST_GAME    = 2'd1;
    localparam logic [1:0] ST_OVER    = 2'd2;
    localparam logic [1:0] ST_CREDITS = 2'd3;

    typedef struct packed {
        logic [11:0] x_min;
        logic [11:0] x_max;
        logic [11:0] y_min;
        logic [11:0] y_max;
    } box_t;

    localparam box_t PLAY_BOX = '{x_min: 12'd270, x_max: 12'd369,
                                  y_min: 12'd200, y_max: 12'd249};
    localparam box_t CRED_BOX = '{x_min: 12'd270, x_max: 12'd369,
                                  y_min: 12'd300, y_max: 12'd349};

    // Bounds are inclusive on all four edges.
    function automatic logic in_box(input box_t b, input logic [11:0] x,
                                    input logic [11:0] y);
        return (x >= b.x_min) && (x <= b.x_max) &&
               (y >= b.y_min) && (y <= b.y_max);
    endfunction

endpackage

// File: rtl/screen_seq_frame_tick.sv
// Frame-edge detector on vsync plus a loadable, saturating down-counter
// that steps once per frame edge and flags when it reads zero.
module frame_tick #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vsync_in,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec_en,
    output logic         fe,
    output logic         zero
);

    logic         vsync_q;
    logic [W-1:0] count;

    assign fe   = vsync_in & ~vsync_q;
    assign zero = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
            count   <= '0;
        end else begin
            vsync_q <= vsync_in;
            if (load)
                count <= load_val;
            else if (fe && dec_en && !zero)
                count <= count - W'(1);
        end
    end

endmodule

// File: rtl/screen_seq.sv
// PONG screen sequencer: runs MENU/GAME/OVER/CREDITS from clicks and the
// game-over flag, switches on frame edges and muxes the chosen pipeline.
module screen_seq
    import pong_screen_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned CRED_FRAMES = 600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync_in,
    input  logic             mouse_left,
    input  logic [11:0]      xpos,
    input  logic [11:0]      ypos,
    input  logic             game_over,
    input  logic             menu_hsync,
    input  logic             menu_vsync,
    input  logic [RGB_W-1:0] menu_rgb,
    input  logic             game_hsync,
    input  logic             game_vsync,
    input  logic [RGB_W-1:0] game_rgb,
    input  logic             cred_hsync,
    input  logic             cred_vsync,
    input  logic [RGB_W-1:0] cred_rgb,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic [1:0]       screen,
    output logic             game_start,
    output logic             cred_restart
);

    localparam int unsigned HOLD_W = ($clog2(HOLD_FRAMES + 1) > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int unsigned CRED_W = ($clog2(CRED_FRAMES) > 10) ? $clog2(CRED_FRAMES) : 10;

    logic [1:0] state;
    logic [1:0] pending;
    logic       pend_v;
    logic [1:0] req;
    logic       req_v;
    logic       mouse_left_q;
    logic       click_ok;
    logic       frame_edge;
    logic       hold_zero;
    logic       cred_fe;
    logic       cred_zero;
    logic       cred_timeout;
    logic       commit;

    assign screen       = state;
    assign commit       = frame_edge & pend_v;
    assign click_ok     = mouse_left & ~mouse_left_q & hold_zero;
    assign cred_timeout = (state == ST_CREDITS) && cred_fe && cred_zero;

    frame_tick #(.W(HOLD_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .load     (commit),
        .load_val (HOLD_W'(HOLD_FRAMES)),
        .dec_en   (1'b1),
        .fe       (frame_edge),
        .zero     (hold_zero)
    );

    // Counts down from CRED_FRAMES-2 so it reads zero on the frame edge at
    // which an up-count from zero would reach CRED_FRAMES-1.
    frame_tick #(.W(CRED_W)) u_cred (
        .clk      (clk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .load     (commit && (pending == ST_CREDITS)),
        .load_val (CRED_W'(CRED_FRAMES - 2)),
        .dec_en   (state == ST_CREDITS),
        .fe       (cred_fe),
        .zero     (cred_zero)
    );

    always_comb begin
        req_v = 1'b0;
        req   = ST_MENU;
        case (state)
            ST_MENU: begin
                if (click_ok && in_box(PLAY_BOX, xpos, ypos)) begin
                    req_v = 1'b1;
                    req   = ST_GAME;
                end else if (click_ok && in_box(CRED_BOX, xpos, ypos)) begin
                    req_v = 1'b1;
                    req   = ST_CREDITS;
                end
            end
            ST_GAME: begin
                if (game_over) begin
                    req_v = 1'b1;
                    req   = ST_OVER;
                end
            end
            ST_OVER: begin
                if (click_ok) begin
                    req_v = 1'b1;
                    req   = ST_MENU;
                end
            end
            ST_CREDITS: begin
                if (click_ok || cred_timeout) begin
                    req_v = 1'b1;
                    req   = ST_MENU;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_MENU;
            pending      <= ST_MENU;
            pend_v       <= 1'b0;
            mouse_left_q <= 1'b0;
            game_start   <= 1'b0;
            cred_restart <= 1'b0;
        end else begin
            mouse_left_q <= mouse_left;
            game_start   <= commit && (pending == ST_GAME);
            cred_restart <= commit && (pending == ST_CREDITS);
            // A request arriving on the committing edge is dropped; one on a
            // non-committing edge is latched and waits for the next edge.
            if (commit) begin
                state  <= pending;
                pend_v <= 1'b0;
            end else if (req_v && !pend_v) begin
                pending <= req;
                pend_v  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            rgb_out   <= '0;
        end else begin
            case (state)
                ST_MENU: begin
                    hsync_out <= menu_hsync;
                    vsync_out <= menu_vsync;
                    rgb_out   <= menu_rgb;
                end
                ST_CREDITS: begin
                    hsync_out <= cred_hsync;
                    vsync_out <= cred_vsync;
                    rgb_out   <= cred_rgb;
                end
                default: begin
                    hsync_out <= game_hsync;
                    vsync_out <= game_vsync;
                    rgb_out   <= game_rgb;
                end
            endcase
        end
    end

endmodule

// File: doc/screen_seq.md
# screen_seq

Top-level screen sequencer for the PONG VGA path. It owns the single VGA output and shares it between the menu, game and credits screen pipelines, selecting one per frame. It runs the menu/game/game-over/credits state machine from mouse clicks and the game-over flag, and switches screens only on frame boundaries. It issues one-cycle restart pulses to the screen pipelines on entry.

## Interface
Parameters:
- HOLD_FRAMES, 30: frames after any screen switch during which clicks are ignored.
- CRED_FRAMES, 600: frames spent in CREDITS before an automatic return to MENU.

Ports:
- clk  in  1  pixel clock; sole clock.
- rst  in  1  reset, asynchronous, active-high.
- vsync_in  in  1  master frame timing; a rising edge marks frame start.
- mouse_left  in  1  left button level, synchronous to clk.
- xpos, ypos  in  12 each  mouse cursor position.
- game_over  in  1  level from the game pipeline.
- menu_hsync, menu_vsync  in  1 each  menu pipeline sync.
- menu_rgb  in  12  menu pipeline pixel.
- game_hsync, game_vsync  in  1 each  game pipeline sync.
- game_rgb  in  12  game pipeline pixel.
- cred_hsync, cred_vsync  in  1 each  credits pipeline sync.
- cred_rgb  in  12  credits pipeline pixel.
- hsync_out, vsync_out  out  1 each  selected sync.
- rgb_out  out  12  selected pixel.
- screen  out  2  current state encoding.
- game_start  out  1  one-cycle pulse on entry to GAME.
- cred_restart  out  1  one-cycle pulse on entry to CREDITS.

## Operation
- States and encoding: MENU=0, GAME=1, OVER=2, CREDITS=3. The reset state is MENU.
- Click detection: `click = mouse_left & ~mouse_left_q`. A click counts only when the hold counter is 0.
- Request sources:
  - MENU, click inside PLAY_BOX: request GAME.
  - MENU, click inside CRED_BOX: request CREDITS.
  - Box bounds are inclusive on all four edges. A click outside both boxes is ignored.
  - GAME, game_over=1: request OVER.
  - OVER, click: request MENU.
  - CREDITS, click: request MENU.
  - CREDITS, frame counter reaches CRED_FRAMES-1 at a frame edge: request MENU.
- Pending register: the first request is latched into `pending` with `pend_v=1`. Further requests are ignored until commit.
- Simultaneous click and credits timeout in the same cycle both request MENU; result is MENU either way.
- Commit happens on the frame edge, defined as `fe = vsync_in & ~vsync_q`.
  - If `pend_v` is set: `state <= pending` and `pend_v <= 0`.
  - The hold counter loads HOLD_FRAMES.
  - game_start or cred_restart pulses for exactly that cycle if the new state is GAME or CREDITS.
- A request raised in the same cycle as fe is latched. It commits on the next frame edge, not the current one.
- Hold counter decrements by 1 on each fe while nonzero, saturating at 0.
- Credits frame counter:
  - 10 bits minimum; width = clog2(CRED_FRAMES).
  - Cleared on commit into CREDITS.
  - Increments on each fe while in CREDITS.
  - Saturates once the request is raised.
- Output mux selects by state:
  - MENU: menu_*.
  - GAME and OVER: game_* (the game pipeline draws its own game-over overlay).
  - CREDITS: cred_*.
- Reset mid-operation: all registers return to reset values immediately; any pending request is lost.

## Timing
- Reset values:
  - screen = 0.
  - rgb_out = 12'h000, hsync_out = 0, vsync_out = 0.
  - game_start = 0, cred_restart = 0.
  - Internal: pend_v = 0, hold = 0, credit counter = 0, mouse_left_q = 0, vsync_q = 0.
- Mux latency is 1 cycle: outputs at cycle n+1 are the inputs of cycle n selected by `state` at cycle n.
- Input pipelines are assumed mutually aligned; the block adds no per-screen compensation.
- Request latency:
  - A click at cycle c sets pend_v at c+1.
  - The commit occurs at the first fe at or after c+1.
  - `screen` changes on the cycle after that fe.
  - rgb_out switches one cycle later still.
- Pulses are high for exactly one clk cycle, aligned with the `screen` change.
- The hold window covers HOLD_FRAMES full frames after the commit. A click on the frame edge that ends the hold is still ignored; the counter reads 0 only from the following cycle.

## Structure
- Shared package `pong_screen_pkg`:
  - State encodings.
  - PLAY_BOX and CRED_BOX bounds as X_MIN, X_MAX, Y_MIN, Y_MAX, 12-bit each; menu drawing uses the same constants.
  - The 12-bit RGB width.
- One natural sub-module, `frame_tick`:
  - vsync rising-edge detector plus a loadable down-counter with zero flag.
  - Instantiated twice: hold counter, and credits timer used as an up-counter compare.

## Test plan
- Reset, then a click at (xpos,ypos) inside PLAY_BOX -> at the next frame edge screen=1, game_start high for 1 cycle, rgb_out=game_rgb one cycle later.
- In GAME, assert game_over -> screen=2 at the next frame edge, and no pulses. Click within HOLD_FRAMES=30 frames -> ignored. Click at frame 31 -> MENU on the following frame edge.
- MENU, click inside CRED_BOX -> cred_restart pulse. With no clicks, screen returns to 0 after exactly CRED_FRAMES frame edges (use CRED_FRAMES=4 in the bench).
- Clicks on every bound pixel of PLAY_BOX -> accepted. Clicks at X_MAX+1 and Y_MIN-1 -> ignored.
- A request raised in the same cycle as fe -> commits on the next fe, not the current one.
- Assert rst mid-frame with pend_v set -> all outputs 0 immediately. After release the state is MENU, and no commit occurs at the next frame edge.
